ccg_sweep_driver: RTL and testbench
===================================

# ccg_sweep_driver

Sequential stimulus-and-capture stage for the combinational CCG benchmark netlists.
- Upstream side: drives an exhaustive 12-bit input sweep onto the benchmark's `x` inputs.
- Downstream side: compacts the benchmark's 16-bit `f` outputs into a MISR signature.
- Original and resynthesised (e.g. RESYN2) variants of one circuit are equivalent on the swept space only if their signatures match.
- Sits between the test controller (start/result handshake) and the benchmark under test.

## Interface
Parameters:
- `IN_W`, 12, benchmark input count; sweep length is 2^IN_W vectors.
- `OUT_W`, 16, benchmark output count; must be ≤ 16.
- `LAT`, 0, cycles from `x` change to a valid `f`; 0 means purely combinational.
- `POLY`, 16'hD008, MISR feedback mask.
- `SEED`, 16'hFFFF, MISR initial value.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin a sweep; sampled in IDLE only.
- `x`, out, IN_W: vector driven to benchmark inputs x0..x(IN_W-1), with bit i driving x_i.
- `f`, in, OUT_W: benchmark outputs f1..f(OUT_W), with f1 on bit 0.
- `busy`, out, 1: high in SWEEP and DRAIN.
- `sig`, out, 16: MISR signature.
- `sig_valid`, out, 1: signature final, held until accepted.
- `sig_ready`, in, 1: controller accepts the signature.

## Operation
- **Reset values:** `x`=0, `sig`=SEED, `busy`=0, `sig_valid`=0, FSM=IDLE, LAT delay line cleared.
- **FSM states:** IDLE, SWEEP, DRAIN, DONE.
- **IDLE:**
  - `start`=1 → SWEEP; `sig`←SEED; vector counter←0.
  - `x`=0.
- **SWEEP:**
  - `x` = current vector.
  - The counter advances by one every cycle.
  - After the vector 2^IN_W−1 is issued: go to DRAIN if LAT>0, otherwise go directly to DONE.
- **DRAIN:**
  - `x`=0.
  - Lasts exactly LAT cycles while the delay line empties.
- **Capture:**
  - A LAT-deep valid delay line tags each issued vector.
  - When a tagged `f` arrives: sig ← {sig[14:0],1'b0} ^ (sig[15] ? POLY : 0) ^ zero-extended `f`.
  - Exactly 2^IN_W updates occur per sweep.
- **DONE:**
  - `sig_valid`=1 and `sig` is frozen.
  - `sig_ready`=1 → IDLE; `sig_valid` drops and `sig` retains its value until the next `start`.
- **Ignored `start`:** `start` in SWEEP, DRAIN or DONE has no effect.
- **Reset mid-sweep:** returns immediately to reset values. The partial signature is discarded; no `sig_valid` pulse.
- **Counter wrap:** the counter is IN_W+1 bits wide so the terminal vector is detected without aliasing.

## Timing
- Counting edges from the edge that samples `start` as edge 0:
  - Vector v is on `x` after edge v.
  - With LAT=0, vector v's response is captured on edge v+1.
- `sig_valid` rises after edge 2^IN_W + LAT.
  - IN_W=12, LAT=0: after edge 4096.
- `sig_ready` already high when `sig_valid` rises → one DONE cycle, then IDLE.
- A new `start` is accepted on the first IDLE cycle.
- `busy` rises after edge 0 and falls together with the rise of `sig_valid`.

## Configuration
- **`CCG_SWEEP_LFSR_EN` undefined:** binary order 0, 1, 2, … 2^IN_W−1.
- **`CCG_SWEEP_LFSR_EN` defined:**
  - Order is 0 first, then a maximal Fibonacci LFSR seeded at 1, taps x^12+x^6+x^4+x+1.
  - This yields 4095 non-zero states, so the sweep still covers all 4096 vectors.
  - LFSR stops after 4095 steps.
  - IN_W≠12 is an elaboration error.
- Cycle counts, handshake and MISR behaviour are identical in both builds.
- Signatures differ between the two builds.

## Test plan
- IN_W=1, LAT=0, `f` tied 0, pulse `start`:
  - `sig_valid` after edge 2.
  - `sig`=16'h2FF6 after the first capture, 16'h5FEC final.
- IN_W=12, LAT=0, `f`={4'b0,x}:
  - `x` steps 0..4095 on consecutive cycles.
  - `sig_valid` after edge 4096.
  - `sig` matches the reference-model MISR.
- IN_W=12, LAT=3, `f`=x delayed 3 cycles:
  - `sig` equals the LAT=0 result.
  - `sig_valid` after edge 4099.
  - DRAIN lasts 3 cycles with `x`=0.
- `start` pulsed mid-sweep; `sig_ready` held low 10 cycles in DONE:
  - Second `start` ignored.
  - `sig_valid` and `sig` stable for 10 cycles.
  - IDLE one cycle after `sig_ready`=1.
- `rst_n` low at vector 1000:
  - All outputs immediately at reset values.
  - No `sig_valid`.
  - Fresh `start` gives the full 4096-vector signature.
- Two netlists that differ only on vector 12'hABC, compared:
  - Final signatures differ.
  - Identical netlists give identical signatures, in both macro builds.

Source files
------------

// File: rtl/ccg_sweep_driver.sv
// ccg_sweep_driver: drives an exhaustive IN_W-bit sweep onto a combinational benchmark
// and compacts its outputs into a 16-bit MISR signature, with a start/result handshake.
// Build option: define CCG_SWEEP_LFSR_EN to issue vectors as 0 followed by a 12-bit
// maximal LFSR sequence instead of binary order (requires IN_W == 12).
module ccg_sweep_driver #(
    parameter int unsigned IN_W  = 12,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned LAT   = 0,
    parameter logic [15:0] POLY  = 16'hD008,
    parameter logic [15:0] SEED  = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [IN_W-1:0]  x,
    input  logic [OUT_W-1:0] f,
    output logic             busy,
    output logic [15:0]      sig,
    output logic             sig_valid,
    input  logic             sig_ready
);

    typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [IN_W:0]   cnt_q, cnt_d;
    logic [IN_W-1:0] vec;
    logic [15:0]     sig_q, sig_d;
    logic [15:0]     f_ext;
    logic            start_ok;
    logic            issue;
    logic            last_vec;
    logic            capture;
    logic            drain_last;

    assign start_ok = (state_q == StIdle) && start;
    assign issue    = (state_q == StSweep);
    // Full-width compare: the extra counter bit keeps the terminal vector unambiguous.
    assign last_vec = issue && (cnt_q == {1'b0, {IN_W{1'b1}}});
    assign f_ext    = 16'(f);

    if (LAT == 0) begin : g_comb
        assign capture    = issue;
        assign drain_last = 1'b1;
    end else begin : g_lat
        localparam int unsigned DW = $clog2(LAT + 1);
        logic [LAT-1:0] tag_q;
        logic [DW-1:0]  drain_q;

        // Delay a valid tag alongside each issued vector; count cycles spent in DRAIN.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tag_q   <= '0;
                drain_q <= '0;
            end else begin
                tag_q   <= (tag_q << 1) | LAT'(issue);
                drain_q <= (state_q == StDrain) ? drain_q + DW'(1) : '0;
            end
        end

        assign capture    = tag_q[LAT-1];
        assign drain_last = (drain_q == DW'(LAT - 1));
    end

`ifdef CCG_SWEEP_LFSR_EN
    if (IN_W != 12) begin : g_bad_in_w
        $error("ccg_sweep_driver: CCG_SWEEP_LFSR_EN requires IN_W == 12");
    end

    logic [IN_W-1:0] lfsr_q, lfsr_d;

    // Vector 0 first, then load 1 and step x^12+x^6+x^4+x+1 until the last vector.
    always_comb begin
        lfsr_d = lfsr_q;
        if (start_ok) begin
            lfsr_d = '0;
        end else if (issue && !last_vec) begin
            if (lfsr_q == '0) begin
                lfsr_d = IN_W'(1);
            end else begin
                lfsr_d = {lfsr_q[IN_W-2:0], lfsr_q[11] ^ lfsr_q[10] ^ lfsr_q[7] ^ lfsr_q[5]};
            end
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= '0;
        else        lfsr_q <= lfsr_d;
    end

    assign vec = lfsr_q;
`else
    assign vec = cnt_q[IN_W-1:0];
`endif

    // Next state, vector counter and MISR update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSweep;
                    cnt_d   = '0;
                end
            end
            StSweep: begin
                cnt_d = cnt_q + 1'b1;
                if (last_vec) state_d = (LAT == 0) ? StDone : StDrain;
            end
            StDrain: begin
                if (drain_last) state_d = StDone;
            end
            StDone: begin
                if (sig_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (start_ok) begin
            sig_d = SEED;
        end else if (capture) begin
            sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ f_ext;
        end
    end

    // State, counter and signature registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sig_q   <= SEED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
        end
    end

    assign x         = issue ? vec : '0;
    assign busy      = (state_q == StSweep) || (state_q == StDrain);
    assign sig_valid = (state_q == StDone);
    assign sig       = sig_q;

endmodule

// File: tb/tb_ccg_sweep_driver.sv
// Bench for ccg_sweep_driver: three instances (IN_W=12/LAT=0, IN_W=12/LAT=3, IN_W=1/LAT=0).
// Stimulus pushes expected signatures and valid edges into a queue; a monitor pops and
// compares on every rising sig_valid.
module tb_ccg_sweep_driver;

    localparam logic [15:0] SEED = 16'hFFFF;
    localparam logic [15:0] POLY = 16'hD008;

    typedef struct {
        int          dut;
        logic [15:0] sig;
        longint      at;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        alt;
    logic        start_a     [3];
    logic        sig_ready_a [3];
    logic        busy_a      [3];
    logic        sig_valid_a [3];
    logic [15:0] sig_a       [3];
    logic [11:0] x0, x1;
    logic [0:0]  x2;
    logic [15:0] f0, f1, f2;
    logic [11:0] d1, d2, d3;

    exp_t        exp_q[$];
    logic [11:0] vecs[4096];
    logic [15:0] ref_norm, ref_alt, sig_norm, sig_alt;
    logic        prev_v[3];
    longint      cyc = 0;
    longint      s_edge;
    int          n_pass = 0;
    int          n_total = 0;

    ccg_sweep_driver #(.IN_W(12), .OUT_W(16), .LAT(0)) u_main (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .x(x0), .f(f0), .busy(busy_a[0]),
        .sig(sig_a[0]), .sig_valid(sig_valid_a[0]), .sig_ready(sig_ready_a[0])
    );

    ccg_sweep_driver #(.IN_W(12), .OUT_W(16), .LAT(3)) u_lat (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .x(x1), .f(f1), .busy(busy_a[1]),
        .sig(sig_a[1]), .sig_valid(sig_valid_a[1]), .sig_ready(sig_ready_a[1])
    );

`ifndef CCG_SWEEP_LFSR_EN
    ccg_sweep_driver #(.IN_W(1), .OUT_W(16), .LAT(0)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_a[2]), .x(x2), .f(f2), .busy(busy_a[2]),
        .sig(sig_a[2]), .sig_valid(sig_valid_a[2]), .sig_ready(sig_ready_a[2])
    );
`else
    assign x2 = '0;
    assign busy_a[2] = 1'b0;
    assign sig_a[2] = SEED;
    assign sig_valid_a[2] = 1'b0;
`endif

    // Benchmark stand-ins: main optionally flips f1 on vector ABC, LAT instance delays x by 3.
    assign f0 = {4'b0, x0} ^ ((alt && x0 == 12'hABC) ? 16'h0001 : 16'h0000);
    assign f1 = {4'b0, d3};
    assign f2 = 16'h0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        d1  <= x1;
        d2  <= d1;
        d3  <= d2;
    end

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] fv);
        return {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0000) ^ fv;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Scoreboard monitor: each rising sig_valid consumes one expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (rst_n && sig_valid_a[d] && !prev_v[d]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sig_valid", d, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("valid_dut", d, e.dut);
                    check("sig", sig_a[d], e.sig);
                    check("valid_edge", cyc, e.at);
                end
            end
        end
        for (int d = 0; d < 3; d++) prev_v[d] <= sig_valid_a[d];
    end

    // Called at a negedge; returns at the negedge just after edge 0 (s_edge = edge 0).
    task automatic pulse_start(input int d, input logic [15:0] e_sig, input int span);
        check("idle_before_start", busy_a[d], 0);
        start_a[d] = 1'b1;
        @(negedge clk);
        start_a[d] = 1'b0;
        s_edge = cyc;
        exp_q.push_back('{dut: d, sig: e_sig, at: cyc + span});
    endtask

    // Walk vectors 0..4095 checking x; optionally pulse start at vector mid_k.
    task automatic walk(input int d, input int mid_k);
        int          bad;
        logic [11:0] xs;
        bad = 0;
        for (int k = 0; k < 4096; k++) begin
            xs = (d == 0) ? x0 : x1;
            if (xs != vecs[k]) bad++;
            if (k == 0) check("busy_rise", busy_a[d], 1);
            start_a[d] = (k == mid_k);
            @(negedge clk);
        end
        start_a[d] = 1'b0;
        check("x_sweep_mismatches", bad, 0);
    endtask

    task automatic wait_valid(input int d, input int budget);
        int n;
        n = 0;
        while (!sig_valid_a[d] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("sig_valid_seen", sig_valid_a[d], 1);
    endtask

    initial begin
        logic [11:0] lf;
        lf = '0;
        // Reference vector order and signatures.
        for (int k = 0; k < 4096; k++) begin
`ifdef CCG_SWEEP_LFSR_EN
            if (k == 1) lf = 12'd1;
            else if (k > 1) lf = {lf[10:0], lf[11] ^ lf[10] ^ lf[7] ^ lf[5]};
            vecs[k] = lf;
`else
            vecs[k] = 12'(k);
`endif
        end
        ref_norm = SEED;
        ref_alt  = SEED;
        for (int k = 0; k < 4096; k++) begin
            ref_norm = misr(ref_norm, {4'b0, vecs[k]});
            ref_alt  = misr(ref_alt, {4'b0, vecs[k]} ^ ((vecs[k] == 12'hABC) ? 16'h1 : 16'h0));
        end

        alt = 1'b0;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            start_a[d] = 1'b0;
            sig_ready_a[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        check("rst_x", x0, 0);
        check("rst_sig", sig_a[0], SEED);
        check("rst_busy", busy_a[0], 0);
        check("rst_valid", sig_valid_a[0], 0);
        rst_n = 1'b1;
        @(negedge clk);

`ifndef CCG_SWEEP_LFSR_EN
        // IN_W=1, f=0: two captures, then back-to-back start on the first IDLE cycle.
        pulse_start(2, 16'h5FEC, 2);
        @(negedge clk);
        check("small_first_capture", sig_a[2], 16'h2FF6);
        check("small_x_v1", x2, 1);
        @(negedge clk);
        check("small_busy_fall", busy_a[2], 0);
        @(negedge clk);
        check("small_idle_valid", sig_valid_a[2], 0);
        check("small_sig_retained", sig_a[2], 16'h5FEC);
        pulse_start(2, 16'h5FEC, 2);
        wait_valid(2, 8);
        @(negedge clk);
`endif

        // Reset at vector 1000: immediate reset values, no result.
        pulse_start(0, ref_norm, 4096);
        repeat (1000) @(negedge clk);
        check("x_at_1000", x0, vecs[1000]);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_x", x0, 0);
        check("midrst_sig", sig_a[0], SEED);
        check("midrst_busy", busy_a[0], 0);
        check("midrst_valid", sig_valid_a[0], 0);
        exp_q.delete(exp_q.size() - 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_idle", busy_a[0], 0);

        // Full sweep with an ignored mid-sweep start and a delayed acceptance.
        sig_ready_a[0] = 1'b0;
        pulse_start(0, ref_norm, 4096);
        walk(0, 500);
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", sig_valid_a[0], 1);
            check("hold_sig", sig_a[0], ref_norm);
            @(negedge clk);
        end
        sig_norm = sig_a[0];
        sig_ready_a[0] = 1'b1;
        @(negedge clk);
        check("accept_valid_drop", sig_valid_a[0], 0);
        check("accept_idle_busy", busy_a[0], 0);
        check("accept_sig_kept", sig_a[0], ref_norm);

        // Netlist differing only on vector ABC, then an identical rerun.
        alt = 1'b1;
        pulse_start(0, ref_alt, 4096);
        walk(0, -1);
        wait_valid(0, 16);
        sig_alt = sig_a[0];
        alt = 1'b0;
        check("alt_sig_differs", sig_alt != sig_norm, 1);
        @(negedge clk);
        pulse_start(0, ref_norm, 4096);
        walk(0, -1);
        wait_valid(0, 16);
        check("identical_rerun", sig_a[0], sig_norm);
        @(negedge clk);

        // LAT=3 with delayed f: same signature, three DRAIN cycles with x=0.
        pulse_start(1, ref_norm, 4099);
        walk(1, -1);
        for (int i = 0; i < 3; i++) begin
            check("drain_busy", busy_a[1], 1);
            check("drain_x", x1, 0);
            check("drain_no_valid", sig_valid_a[1], 0);
            @(negedge clk);
        end
        wait_valid(1, 8);
        check("lat_busy_fall", busy_a[1], 0);
        @(negedge clk);
        check("lat_one_done_cycle", sig_valid_a[1], 0);

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
